// File: rtl/dmem_ctl.sv
// Single-port data memory with byte enables, pipelined loads (RD_LAT 1 or 2) and a post-reset clear sequencer.
// Optional macro DMEM_BOOT_INIT_EN adds a 5-word boot table written after the clear pass.
module dmem_ctl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_CLEAR, S_BOOT, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_accept;
    logic                r_vld_p0;
    logic [ADDR_W-1:0]   r_addr_p0;
    logic                w_vld_last;
    logic [DATA_W-1:0]   w_data_last;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;

`ifdef DMEM_BOOT_INIT_EN
    logic [2:0] r_boot_idx;

    function automatic logic [DATA_W-1:0] boot_word(input logic [2:0] idx);
        logic [15:0] v;
        case (idx)
            3'd0:    v = 16'h2BCD;
            3'd1:    v = 16'h0000;
            3'd2:    v = 16'h1234;
            3'd3:    v = 16'hDEAD;
            3'd4:    v = 16'hBEEF;
            default: v = 16'h0000;
        endcase
        return DATA_W'(v);
    endfunction

    function automatic logic [ADDR_W-1:0] boot_addr(input logic [2:0] idx);
        return ADDR_W'({idx, 1'b0});
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_boot_idx <= 3'd0;
        else if (r_state == S_BOOT)
            r_boot_idx <= r_boot_idx + 3'd1;
    end
`endif

    assign w_accept = req_valid && req_ready;

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == '1) begin
`ifdef DMEM_BOOT_INIT_EN
                    w_state_nxt = S_BOOT;
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_BOOT: begin
`ifdef DMEM_BOOT_INIT_EN
                if (r_boot_idx == 3'd4)
                    w_state_nxt = S_RUN;
`else
                w_state_nxt = S_RUN;
`endif
            end
            S_RUN: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Clear counter parks on the top address instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR)
            r_mem[r_cnt] <= '0;
`ifdef DMEM_BOOT_INIT_EN
        if (r_state == S_BOOT)
            r_mem[boot_addr(r_boot_idx)] <= boot_word(r_boot_idx);
`endif
        if (w_accept && req_we) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i])
                    r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    // Stage p0: load accepted, address captured
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_vld_p0 <= 1'b0;
        else
            r_vld_p0 <= w_accept && !req_we;
    end

    always_ff @(posedge clk) begin
        if (w_accept && !req_we)
            r_addr_p0 <= req_addr;
    end

    // Stage p1: array read, registered once more only for the two-cycle latency build
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic                r_vld_p1;
            logic [DATA_W-1:0]   r_data_p1;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_vld_p1 <= 1'b0;
                else
                    r_vld_p1 <= r_vld_p0;
            end

            always_ff @(posedge clk) begin
                if (r_vld_p0)
                    r_data_p1 <= r_mem[r_addr_p0];
            end

            assign w_vld_last  = r_vld_p1;
            assign w_data_last = r_data_p1;
        end else begin : g_lat1
            assign w_vld_last  = r_vld_p0;
            assign w_data_last = r_mem[r_addr_p0];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_vld_last;
            if (w_vld_last)
                r_rsp_rdata <= w_data_last;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_ctl.sv
// Bench for dmem_ctl: one RD_LAT=1 and one RD_LAT=2 instance share stimulus, checked against a queue-based model.
module tb_dmem_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [15:0] req_wdata = 16'h0000;
    logic [1:0]  req_be = 2'b00;

    logic        rdy1, busy1, vld1;
    logic [15:0] rd1;
    logic        rdy2, busy2, vld2;
    logic [15:0] rd2;

    always #5 clk = ~clk;

    dmem_ctl #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld1), .rsp_rdata(rd1), .busy(busy1)
    );

    dmem_ctl #(.DATA_W(16), .ADDR_W(8), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld2), .rsp_rdata(rd2), .busy(busy2)
    );

`ifdef DMEM_BOOT_INIT_EN
    localparam int          INIT_CYC = 261;
    localparam logic [15:0] E0 = 16'h2BCD;
    localparam logic [15:0] E4 = 16'h1234;
    localparam logic [15:0] E8 = 16'hBEEF;
`else
    localparam int          INIT_CYC = 256;
    localparam logic [15:0] E0 = 16'h0000;
    localparam logic [15:0] E4 = 16'h0000;
    localparam logic [15:0] E8 = 16'h0000;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mm [256];
    logic [15:0] boot_tab [5] = '{16'h2BCD, 16'h0000, 16'h1234, 16'hDEAD, 16'hBEEF};
    int          e_since = 0;
    int          gcyc = 0;
    int          due1 [$];
    int          due2 [$];
    logic [15:0] dq1 [$];
    logic [15:0] dq2 [$];
    logic        m_vld1 = 1'b0, m_vld2 = 1'b0;
    logic [15:0] m_dat1 = 16'h0, m_dat2 = 16'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_since = 0;
            due1.delete(); due2.delete(); dq1.delete(); dq2.delete();
            m_vld1 = 1'b0; m_vld2 = 1'b0; m_dat1 = 16'h0; m_dat2 = 16'h0;
        end else begin
            gcyc++;
            m_vld1 = 1'b0;
            m_vld2 = 1'b0;
            if (due1.size() > 0 && due1[0] == gcyc) begin
                m_vld1 = 1'b1; m_dat1 = dq1.pop_front(); void'(due1.pop_front());
            end
            if (due2.size() > 0 && due2[0] == gcyc) begin
                m_vld2 = 1'b1; m_dat2 = dq2.pop_front(); void'(due2.pop_front());
            end
            if (e_since >= INIT_CYC && req_valid) begin
                if (req_we) begin
                    if (req_be[0]) mm[req_addr][7:0]  = req_wdata[7:0];
                    if (req_be[1]) mm[req_addr][15:8] = req_wdata[15:8];
                end else begin
                    due1.push_back(gcyc + 1); dq1.push_back(mm[req_addr]);
                    due2.push_back(gcyc + 2); dq2.push_back(mm[req_addr]);
                end
            end
            if (e_since < INIT_CYC) begin
                e_since++;
                if (e_since == INIT_CYC) begin
                    for (int i = 0; i < 256; i++) mm[i] = 16'h0000;
`ifdef DMEM_BOOT_INIT_EN
                    for (int i = 0; i < 5; i++) mm[2*i] = boot_tab[i];
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ready1", rdy1, e_since >= INIT_CYC);
        chk("busy1",  busy1, e_since < INIT_CYC);
        chk("vld1",   vld1, m_vld1);
        chk("rdata1", rd1,  m_dat1);
        chk("ready2", rdy2, e_since >= INIT_CYC);
        chk("busy2",  busy2, e_since < INIT_CYC);
        chk("vld2",   vld2, m_vld2);
        chk("rdata2", rd2,  m_dat2);
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic we, input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic wait_init(input bit hold);
        int n;
        n = 0;
        if (hold) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 16'hFFFF; req_be = 2'b11;
        end
        while (busy1 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (n == 100) req_we = 1'b0;
            if (n == 200) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk("init_len", n, INIT_CYC);
        chk("init_ready", rdy1, 1);
    endtask

    task automatic load_chk(input string nm, input logic [7:0] a, input logic [15:0] expv);
        int lat;
        lat = 0;
        issue(1'b0, a, 16'h0, 2'b00);
        idle();
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (vld1) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_lat"}, lat, 1);
        chk({nm, "_data"}, rd1, expv);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", rdy1, 0);
        chk("rst_busy", busy1, 1);
        chk("rst_vld", vld1, 0);
        chk("rst_rdata", rd1, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_init(1'b1);

        load_chk("boot4", 8'h04, E4);
        load_chk("boot8", 8'h08, E8);
        load_chk("clr10", 8'h10, 16'h0000);
        load_chk("hold40", 8'h40, 16'h0000);

        issue(1'b1, 8'h20, 16'hA5A5, 2'b11);
        issue(1'b1, 8'h20, 16'hFFFF, 2'b01);
        idle();
        load_chk("be_lo", 8'h20, 16'hA5FF);
        issue(1'b1, 8'h20, 16'h1234, 2'b00);
        idle();
        load_chk("be_none", 8'h20, 16'hA5FF);
        issue(1'b1, 8'h20, 16'h3C00, 2'b10);
        idle();
        load_chk("be_hi", 8'h20, 16'h3CFF);

        issue(1'b1, 8'h30, 16'h5555, 2'b11);
        load_chk("raw", 8'h30, 16'h5555);

        issue(1'b1, 8'hFF, 16'hCAFE, 2'b11);
        idle();
        load_chk("top", 8'hFF, 16'hCAFE);
        load_chk("wrap0", 8'h00, E0);

        issue(1'b1, 8'h00, 16'h1111, 2'b11);
        issue(1'b1, 8'h02, 16'h2222, 2'b11);
        issue(1'b1, 8'h04, 16'h3333, 2'b11);
        issue(1'b0, 8'h00, 16'h0, 2'b00);
        chk("l2_n0_vld", vld2, 0);
        issue(1'b0, 8'h02, 16'h0, 2'b00);
        chk("l2_n1_vld", vld2, 0);
        issue(1'b0, 8'h04, 16'h0, 2'b00);
        idle();
        chk("l2_n2_vld", vld2, 1);
        chk("l2_n2_data", rd2, 16'h1111);
        @(posedge clk); #1;
        chk("l2_n3_vld", vld2, 1);
        chk("l2_n3_data", rd2, 16'h2222);
        @(posedge clk); #1;
        chk("l2_n4_vld", vld2, 1);
        chk("l2_n4_data", rd2, 16'h3333);
        @(posedge clk); #1;
        chk("l2_n5_vld", vld2, 0);
        chk("l2_n5_hold", rd2, 16'h3333);

        issue(1'b1, 8'h50, 16'h7777, 2'b11);
        issue(1'b0, 8'h50, 16'h0, 2'b00);
        issue(1'b0, 8'h50, 16'h0, 2'b00);
        idle();
        chk("pre_rst_vld", vld1, 1);
        chk("pre_rst_data", rd1, 16'h7777);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_vld1", vld1, 0);
        chk("mid_rst_rd1", rd1, 0);
        chk("mid_rst_vld2", vld2, 0);
        chk("mid_rst_rd2", rd2, 0);
        @(posedge clk); #1 rst = 1'b0;
        wait_init(1'b0);
        load_chk("reclr50", 8'h50, 16'h0000);
        load_chk("reclr20", 8'h20, 16'h0000);
        load_chk("reboot4", 8'h04, E4);

        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctl.md
# dmem_ctl

Parametrised single-port data memory for the datapath's load/store stage. Supports configurable width and depth, per-byte write enables, a valid/ready request handshake, pipelined reads with configurable latency and a hardware clear sequencer that zeroes the array after reset. Sits between the ALU/address path and the register-file write-back mux, replacing the fixed 256 x 16 store.

## Interface
Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8
- ADDR_W, 8, address width; depth is 2**ADDR_W words
- RD_LAT, 1, read latency in cycles from request acceptance to rsp_valid; legal values 1 or 2

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_be  in  DATA_W/8  byte enables for stores; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  one-cycle pulse, load data valid
- rsp_rdata  out  DATA_W  load data; holds last value between responses
- busy  out  1  clear/boot sequence in progress

## Operation
- Accept: request accepted on a rising edge where req_valid && req_ready.
- FSM states: CLEAR -> BOOT (only with DMEM_BOOT_INIT_EN) -> RUN. RUN is terminal until reset.
- CLEAR: counter walks 0 .. 2**ADDR_W-1, writes 0 to one word per cycle. busy=1, req_ready=0.
- BOOT: 5 cycles, writes the boot table (see Configuration). busy=1, req_ready=0.
- RUN: req_ready=1 every cycle, busy=0. One request per cycle.
- Store: each byte lane with req_be[i]=1 is updated at the accept edge; other lanes are unchanged. req_be all zero is a no-op. No response is generated.
- Load: the word at req_addr is returned RD_LAT cycles after the accept edge. Back-to-back loads are fully pipelined, giving one response per cycle.
- A load accepted the cycle after a store to the same address returns the new data.
- Loads issued during CLEAR/BOOT are not possible because req_ready=0. req_valid is ignored there.
- req_we, req_addr, req_wdata and req_be are sampled only at accept.

## Timing
- Reset values: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, state=CLEAR, clear counter=0, read pipeline empty.
- CLEAR lasts exactly 2**ADDR_W cycles after reset release. That is 256 cycles for the defaults.
- BOOT, when compiled in, adds 5 cycles.
- First RUN cycle: busy falls and req_ready rises on the same edge.
- Load: accepted at edge N, so rsp_valid=1 and rsp_rdata is valid after edge N+RD_LAT, for one cycle.
- Reset asserted mid-operation:
  - in-flight loads are discarded and rsp_valid drops immediately;
  - array contents are undefined until CLEAR re-runs from address 0.
- Address wraps naturally: the top word 2**ADDR_W-1 is an ordinary location. The clear counter stops there; it does not wrap.

## Configuration
- DMEM_BOOT_INIT_EN defined:
  - the BOOT state follows CLEAR and writes words 0x0/0x2/0x4/0x6/0x8 = 16'h2BCD/16'h0000/16'h1234/16'hDEAD/16'hBEEF, one per cycle;
  - values are zero-extended or truncated to DATA_W;
  - total busy time is 2**ADDR_W+5 cycles.
- DMEM_BOOT_INIT_EN undefined: BOOT is absent, CLEAR goes directly to RUN, and all words read 0 after init.

## Test plan
- Reset then wait with defaults and DMEM_BOOT_INIT_EN:
  - busy=1 and req_ready=0 for 261 cycles, then busy=0 and req_ready=1;
  - loads of 0x4 and 0x8 return 16'h1234 and 16'hBEEF;
  - a load of 0x10 returns 0.
- Store 0xA5A5 to 0x20 with be=2'b11, then store 0xFFFF to 0x20 with be=2'b01. A load of 0x20 returns 16'hA5FF.
- Store 0x5555 to 0x30 at edge N, then load 0x30 at edge N+1. With RD_LAT=1, rsp_valid pulses after edge N+2 with 16'h5555.
- RD_LAT=2: loads of 0x0, 0x2, 0x4 on three consecutive cycles. rsp_valid is high for exactly three consecutive cycles starting 2 cycles after the first accept, with data in order.
- Hold req_valid=1 during CLEAR: no accept, no store, no rsp_valid.
- Assert reset while 2 loads are in flight:
  - rsp_valid=0 and rsp_rdata=0 immediately;
  - no late responses arrive;
  - a previously stored nonzero word reads 0 after the re-clear.
